// File: rtl/riscv_pkg.sv
// Shared architectural constants for the instruction-fetch front end.
package riscv_pkg;

   localparam int          XLEN        = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush. Read data comes from the head entry
// without a register stage.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_r [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W:0]    count_r;
   logic              do_pop_s;
   logic              do_push_s;

   assign do_pop_s  = pop && (count_r != '0);
   assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Entry storage; contents are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush && !rst) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy tracking; flush outranks any push/pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches under a credit
// limit, tags returned instructions with their PC and buffers them for decode.
module fetch_queue #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [XLEN-1:0]   imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_instr,
   input  logic              out_ready
);

   import riscv_pkg::*;

   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);
   localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(DEPTH);

   logic [XLEN-1:0]   fetch_pc_r;
   logic [XLEN-1:0]   resp_pc_r;
   logic [CNT_W-1:0]  outstanding_r;
   logic [CNT_W-1:0]  drop_cnt_r;
   logic [CNT_W-1:0]  fifo_count_s;
   logic [CNT_W-1:0]  rsp_dec_s;
   logic [2*XLEN-1:0] head_s;
   logic              credit_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;

   // Credits cover both buffered entries and fetches still in memory, so a
   // response always finds room; only registered state feeds this compare.
   assign credit_s       = ({1'b0, fifo_count_s} + {1'b0, outstanding_r}) < CREDITS;
   assign imem_req_valid = !rst && !redirect_valid && credit_s;
   assign imem_req_addr  = fetch_pc_r;
   assign accept_s       = imem_req_valid && imem_req_ready;
   assign push_s         = imem_rsp_valid && (drop_cnt_r == '0) && !redirect_valid && !rst;
   assign pop_s          = out_valid && out_ready;
   assign rsp_dec_s      = outstanding_r - CNT_W'(imem_rsp_valid);

   assign out_valid = !rst && (fifo_count_s != '0);
   assign out_pc    = out_valid ? head_s[2*XLEN-1:XLEN] : '0;
   assign out_instr = out_valid ? head_s[XLEN-1:0]      : '0;

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push_s),
      .wdata ({resp_pc_r, imem_rsp_data}),
      .pop   (pop_s),
      .rdata (head_s),
      .count (fifo_count_s)
   );

   // PC tracking and in-flight accounting; a redirect turns every fetch still
   // in memory (minus one answering this cycle) into a response to discard.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= '0;
         drop_cnt_r    <= '0;
      end else if (redirect_valid) begin
         fetch_pc_r    <= {redirect_pc[XLEN-1:2], 2'b00};
         resp_pc_r     <= {redirect_pc[XLEN-1:2], 2'b00};
         outstanding_r <= rsp_dec_s;
         drop_cnt_r    <= rsp_dec_s;
      end else begin
         if (accept_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
         if (push_s)   resp_pc_r  <= resp_pc_r + PC_STEP;
         case ({accept_s, imem_rsp_valid})
            2'b10:   outstanding_r <= outstanding_r + 1'b1;
            2'b01:   outstanding_r <= outstanding_r - 1'b1;
            default: outstanding_r <= outstanding_r;
         endcase
         if (imem_rsp_valid && (drop_cnt_r != '0)) drop_cnt_r <= drop_cnt_r - 1'b1;
      end
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting between the program counter and instruction memory on one side and decode/execute on the other.
- Owns the fetch PC and issues sequential word fetches to instruction memory, which may have variable latency.
- Buffers returned instructions, each tagged with its PC, in a small FIFO. Delivers them to the consumer over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches and restarts fetch at a new PC.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, number of FIFO entries and maximum requests in flight plus buffered; must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  instruction returned; responses are in request order.
- imem_rsp_data  in  XLEN  returned instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and treated as 00.
- out_valid  out  1  instruction available to the consumer.
- out_pc  out  XLEN  PC of the head instruction.
- out_instr  out  XLEN  head instruction.
- out_ready  in  1  consumer accepts the head instruction.

Behaviour:
- Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO count=0, pointers=0, outstanding=0, drop_cnt=0.
- Outputs during and after reset: out_valid=0, imem_req_valid=0; out_pc and out_instr read 0.
- Instruction memory shares rst and must discard its own in-flight responses on reset.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH). This guarantees the FIFO never overflows.
- imem_req_addr = fetch_pc, combinational.
- Request accepted (imem_req_valid && imem_req_ready): fetch_pc += 4, wrapping modulo 2^XLEN; outstanding += 1.
- Response with drop_cnt>0: discard it; drop_cnt -= 1; outstanding -= 1.
- Response with drop_cnt==0: push {resp_pc, imem_rsp_data}; resp_pc += 4; outstanding -= 1.
- Pop on out_valid && out_ready. out_valid = (count != 0). out_pc and out_instr come combinationally from the head entry, so pop-to-consumer latency is 0.
- Request-to-output latency: memory latency + 1 cycle (registered FIFO write).
- Push and pop in the same cycle: count unchanged; both pointers advance modulo DEPTH.
- Accept and response in the same cycle: outstanding unchanged.
- Redirect (has priority over every other update in the same cycle):
  - count, rd_ptr and wr_ptr go to 0.
  - fetch_pc and resp_pc go to {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt <= outstanding - imem_rsp_valid. Any response arriving in the redirect cycle is itself dropped.
  - outstanding <= outstanding - imem_rsp_valid.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is still a completed handshake from the consumer's view; the flush then removes the remaining entries.
  - First post-redirect request is issued the next cycle.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding; the last redirect wins.
- Empty FIFO with consumer ready: out_valid=0, no state change.
- Full FIFO (count==DEPTH): no requests issued. Pop frees exactly one credit, usable the next cycle.
- Stalled memory (imem_req_ready=0): request and address are held stable until accepted or a redirect occurs.
- No combinational path from imem_rsp_* to out_*.
- No combinational path from out_ready to imem_req_valid. Credits are computed from registered count and outstanding.

Decomposition:
- riscv_pkg: XLEN, RESET_PC, INSTR_BYTES=4.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, flush, push, wdata, pop, rdata, count) holds the {pc, instr} entries. The fetch_queue top holds fetch_pc, resp_pc, the outstanding/drop counters and the credit logic.

Test Plan:
- Zero-latency memory, out_ready=1: after rst deassert, out_pc sequence is 0x0, 0x4, 0x8, 0xC on consecutive cycles. out_instr matches memory words; first out_valid appears 1 cycle after the first accept.
- out_ready=0 for 10 cycles, DEPTH=4: exactly 4 requests accepted, then imem_req_valid=0, count=4. One pop produces exactly one new request the next cycle.
- 3-cycle memory latency with 2 in flight, then redirect_pc=0x100: both stale responses are dropped; the next out_pc=0x100 and out_instr=mem[0x100]; no entry with PC 0x8 or 0xC appears.
- Response arriving in the same cycle as redirect_pc=0x203: that response is discarded; fetch restarts at 0x200.
- Simultaneous push and pop with DEPTH=4 over 20 cycles: count stays constant; entries are in order across pointer wrap.
- rst asserted mid-stream (count=3, outstanding=1): next cycle out_valid=0 and imem_req_valid=0. After release, fetch restarts at RESET_PC.
